// File: rtl/alu_arbiter_if.sv
// Signal bundle for alu_arbiter: two request ports, the ALU drive/return lines and the response channel.
// The ALU flag lines and the returned flags exist only when ALU_ARB_FLAGS_EN is defined.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             r0_valid;
    logic             r0_ready;
    logic [3:0]       r0_select;
    logic [WIDTH-1:0] r0_a;
    logic [WIDTH-1:0] r0_b;

    logic             r1_valid;
    logic             r1_ready;
    logic [3:0]       r1_select;
    logic [WIDTH-1:0] r1_a;
    logic [WIDTH-1:0] r1_b;

    logic [3:0]       alu_select;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;

`ifdef ALU_ARB_FLAGS_EN
    logic             alu_carry_out;
    logic             alu_overflow;
    logic             alu_zero;
    logic             rsp_carry;
    logic             rsp_overflow;
    logic             rsp_zero;
`endif

    modport slave (
        input  r0_valid, r0_select, r0_a, r0_b,
        input  r1_valid, r1_select, r1_a, r1_b,
        input  alu_result, rsp_ready,
`ifdef ALU_ARB_FLAGS_EN
        input  alu_carry_out, alu_overflow, alu_zero,
        output rsp_carry, rsp_overflow, rsp_zero,
`endif
        output r0_ready, r1_ready,
        output alu_select, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport master (
        output r0_valid, r0_select, r0_a, r0_b,
        output r1_valid, r1_select, r1_a, r1_b,
        output alu_result, rsp_ready,
`ifdef ALU_ARB_FLAGS_EN
        output alu_carry_out, alu_overflow, alu_zero,
        input  rsp_carry, rsp_overflow, rsp_zero,
`endif
        input  r0_ready, r1_ready,
        input  alu_select, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with a settle delay and a
// tagged valid/ready response. Define ALU_ARB_FLAGS_EN to also capture and return the ALU flags.
module alu_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_arbiter: SETTLE_CYCLES must lie in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic [3:0]       cnt;

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             win_id;
    logic [3:0]       win_select;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_legal;

    logic [3:0]       alu_select_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_err_q;

    function automatic logic is_legal(input logic [3:0] sel);
        case (sel)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
            4'b1000, 4'b1010, 4'b1100, 4'b1110: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // A lone valid requester wins; on a tie prio names the winner.
    assign gnt0       = (state == IDLE) && bus.r0_valid && (!bus.r1_valid || !prio);
    assign gnt1       = (state == IDLE) && bus.r1_valid && (!bus.r0_valid ||  prio);
    assign accept     = gnt0 || gnt1;
    assign win_id     = gnt1;
    assign win_select = gnt1 ? bus.r1_select : bus.r0_select;
    assign win_a      = gnt1 ? bus.r1_a      : bus.r0_a;
    assign win_b      = gnt1 ? bus.r1_b      : bus.r0_b;
    assign win_legal  = is_legal(win_select);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = win_legal ? EXEC : RESP;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio         <= 1'b0;
            cnt          <= 4'd0;
            alu_select_q <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prio     <= ~win_id;
                        rsp_id_q <= win_id;
                        if (win_legal) begin
                            alu_select_q <= win_select;
                            alu_a_q      <= win_a;
                            alu_b_q      <= win_b;
                            cnt          <= CNT_LOAD;
                        end else begin
                            // Illegal codes bypass the ALU and leave its inputs untouched.
                            rsp_result_q <= '0;
                            rsp_err_q    <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result_q <= bus.alu_result;
                        rsp_err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic rsp_carry_q;
    logic rsp_overflow_q;
    logic rsp_zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
        end else if (accept && !win_legal) begin
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
        end else if (state == EXEC && cnt == 4'd0) begin
            rsp_carry_q    <= bus.alu_carry_out;
            rsp_overflow_q <= bus.alu_overflow;
            rsp_zero_q     <= bus.alu_zero;
        end
    end

    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_zero     = rsp_zero_q;
`endif

    // Ready is gated by reset so an asserted reset forces every output low at once.
    assign bus.r0_ready   = gnt0 && !reset;
    assign bus.r1_ready   = gnt1 && !reset;
    assign bus.alu_select = alu_select_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter: two instances (settle 1 and settle 3) each driven
// against a transaction-level reference of grant order, latency and returned values.
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) ifa ();
    alu_arbiter_if #(.WIDTH(W)) ifb ();

    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    // Stimulus per instance: index 0 -> dut_a, index 1 -> dut_b.
    logic         v0 [2];
    logic         v1 [2];
    logic         rr [2];
    logic [3:0]   s0 [2];
    logic [3:0]   s1 [2];
    logic [W-1:0] a0 [2];
    logic [W-1:0] b0 [2];
    logic [W-1:0] a1 [2];
    logic [W-1:0] b1 [2];

    wire          rdy0 [2];
    wire          rdy1 [2];
    wire          rv   [2];
    wire          rid  [2];
    wire          rerr [2];
    wire [W-1:0]  rres [2];
    wire [3:0]    asel [2];
    wire [W-1:0]  aa   [2];
    wire [W-1:0]  ab   [2];

    int n_tests;
    int n_fail;
    bit prio_m [2];

    function automatic logic [W-1:0] alu_ref(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        case (sel)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h4:    return a | b;
            4'h6:    return a ^ b;
            4'h8:    return a << b[4:0];
            4'hA:    return a >> b[4:0];
            4'hC:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hE:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] sel);
        return sel inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE};
    endfunction

    function automatic int settle(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    assign ifa.r0_valid = v0[0];  assign ifb.r0_valid = v0[1];
    assign ifa.r1_valid = v1[0];  assign ifb.r1_valid = v1[1];
    assign ifa.r0_select = s0[0]; assign ifb.r0_select = s0[1];
    assign ifa.r1_select = s1[0]; assign ifb.r1_select = s1[1];
    assign ifa.r0_a = a0[0];      assign ifb.r0_a = a0[1];
    assign ifa.r0_b = b0[0];      assign ifb.r0_b = b0[1];
    assign ifa.r1_a = a1[0];      assign ifb.r1_a = a1[1];
    assign ifa.r1_b = b1[0];      assign ifb.r1_b = b1[1];
    assign ifa.rsp_ready = rr[0]; assign ifb.rsp_ready = rr[1];
    assign ifa.alu_result = alu_ref(ifa.alu_select, ifa.alu_a, ifa.alu_b);
    assign ifb.alu_result = alu_ref(ifb.alu_select, ifb.alu_a, ifb.alu_b);

    assign rdy0[0] = ifa.r0_ready;   assign rdy0[1] = ifb.r0_ready;
    assign rdy1[0] = ifa.r1_ready;   assign rdy1[1] = ifb.r1_ready;
    assign rv[0]   = ifa.rsp_valid;  assign rv[1]   = ifb.rsp_valid;
    assign rid[0]  = ifa.rsp_id;     assign rid[1]  = ifb.rsp_id;
    assign rerr[0] = ifa.rsp_err;    assign rerr[1] = ifb.rsp_err;
    assign rres[0] = ifa.rsp_result; assign rres[1] = ifb.rsp_result;
    assign asel[0] = ifa.alu_select; assign asel[1] = ifb.alu_select;
    assign aa[0]   = ifa.alu_a;      assign aa[1]   = ifb.alu_a;
    assign ab[0]   = ifa.alu_b;      assign ab[1]   = ifb.alu_b;

`ifdef ALU_ARB_FLAGS_EN
    function automatic logic [2:0] alu_flags(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        logic       c;
        logic       o;
        c = 1'b0;
        o = 1'b0;
        if (sel == 4'h0) begin
            s = {1'b0, a} + {1'b0, b};
            c = s[W];
            o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else if (sel == 4'h1) begin
            s = {1'b0, a} - {1'b0, b};
            c = s[W];
            o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {c, o, alu_ref(sel, a, b) == '0};
    endfunction

    wire [2:0] rfl [2];
    assign {ifa.alu_carry_out, ifa.alu_overflow, ifa.alu_zero} = alu_flags(ifa.alu_select, ifa.alu_a, ifa.alu_b);
    assign {ifb.alu_carry_out, ifb.alu_overflow, ifb.alu_zero} = alu_flags(ifb.alu_select, ifb.alu_a, ifb.alu_b);
    assign rfl[0] = {ifa.rsp_carry, ifa.rsp_overflow, ifa.rsp_zero};
    assign rfl[1] = {ifb.rsp_carry, ifb.rsp_overflow, ifb.rsp_zero};
`endif

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input int d);
        check("rst_ready0", rdy0[d], 0);
        check("rst_ready1", rdy1[d], 0);
        check("rst_rsp_valid", rv[d], 0);
        check("rst_rsp_id", rid[d], 0);
        check("rst_rsp_err", rerr[d], 0);
        check("rst_rsp_result", rres[d], 0);
        check("rst_alu_select", asel[d], 0);
        check("rst_alu_a", aa[d], 0);
        check("rst_alu_b", ab[d], 0);
`ifdef ALU_ARB_FLAGS_EN
        check("rst_flags", rfl[d], 0);
`endif
    endtask

    // Called just after a rising edge with the instance idle; returns just after the response handshake edge.
    task automatic run_op(input int d, input bit w0, input bit w1,
                          input logic [3:0] sl0, input logic [3:0] sl1,
                          input logic [W-1:0] x0, input logic [W-1:0] y0,
                          input logic [W-1:0] x1, input logic [W-1:0] y1,
                          input int bp, output logic [W-1:0] got_res, output logic got_id);
        int           win;
        int           lat;
        bit           lg;
        logic [3:0]   sel;
        logic [W-1:0] ea, eb, eres;
        logic [3:0]   old_sel;
        logic [W-1:0] old_a, old_b;

        v0[d] = w0; s0[d] = sl0; a0[d] = x0; b0[d] = y0;
        v1[d] = w1; s1[d] = sl1; a1[d] = x1; b1[d] = y1;
        rr[d] = 1'b0;
        win  = (w0 && w1) ? (prio_m[d] ? 1 : 0) : (w1 ? 1 : 0);
        sel  = win ? sl1 : sl0;
        ea   = win ? x1 : x0;
        eb   = win ? y1 : y0;
        lg   = legal(sel);
        lat  = lg ? settle(d) + 1 : 1;
        eres = lg ? alu_ref(sel, ea, eb) : '0;
        old_sel = asel[d]; old_a = aa[d]; old_b = ab[d];

        @(negedge clk);
        check("idle_rsp_valid", rv[d], 0);
        check("grant_ready0", rdy0[d], win == 0);
        check("grant_ready1", rdy1[d], win == 1);
        @(posedge clk);
        #1;
        prio_m[d] = (win == 0);
        if (win == 0) begin
            v0[d] = 1'b0; s0[d] = 4'($urandom); a0[d] = $urandom; b0[d] = $urandom;
        end else begin
            v1[d] = 1'b0; s1[d] = 4'($urandom); a1[d] = $urandom; b1[d] = $urandom;
        end

        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("rsp_valid_timing", rv[d], k == lat);
            check("busy_ready", {rdy0[d], rdy1[d]}, 0);
            if (lg && k <= settle(d)) begin
                check("alu_select_held", asel[d], sel);
                check("alu_a_held", aa[d], ea);
                check("alu_b_held", ab[d], eb);
            end else if (!lg) begin
                check("alu_select_kept", asel[d], old_sel);
                check("alu_ab_kept", {aa[d] ^ ab[d]}, old_a ^ old_b);
            end
        end
        check("rsp_id", rid[d], win);
        check("rsp_err", rerr[d], !lg);
        check("rsp_result", rres[d], eres);
`ifdef ALU_ARB_FLAGS_EN
        check("rsp_flags", rfl[d], lg ? alu_flags(sel, ea, eb) : 3'b000);
`endif
        got_res = rres[d];
        got_id  = rid[d];

        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", rv[d], 1);
            check("bp_ready", {rdy0[d], rdy1[d]}, 0);
            check("bp_rsp_result", rres[d], eres);
            check("bp_rsp_id", rid[d], win);
            check("bp_rsp_err", rerr[d], !lg);
        end
        rr[d] = 1'b1;
        @(posedge clk);
        #1;
        rr[d] = 1'b0;
        v0[d] = 1'b0;
        v1[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic         id;
        bit           w0, w1;

        n_tests = 0;
        n_fail  = 0;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 1'b1; v1[d] = 1'b1; rr[d] = 1'b0; prio_m[d] = 1'b0;
            s0[d] = 4'h0; s1[d] = 4'h0; a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
        end
        reset = 1'b1;
        #12;
        check_zero(0);
        check_zero(1);
        for (int d = 0; d < 2; d++) begin
            v0[d] = 1'b0; v1[d] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin from reset with both requesters continuously valid.
        for (int i = 0; i < 4; i++) begin
            run_op(0, 1, 1, 4'h1, 4'h6, 32'hFFFF_FFFF, 32'h1, 32'h5555_5555, 32'hAAAA_AAAA, 0, r, id);
            check("rr_id", id, i % 2);
            check("rr_result", r, (i % 2) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
        end

        // Single op, settle 1.
        run_op(0, 1, 0, 4'h0, 4'h0, 32'd4, 32'd4, 32'd0, 32'd0, 0, r, id);
        check("single_result", r, 32'd8);
        check("single_id", id, 0);

        // Back-pressure followed directly by the next accept.
        run_op(0, 1, 1, 4'h2, 4'h4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h1, 32'h2, 5, r, id);
        run_op(0, 1, 1, 4'h8, 4'hA, 32'h1, 32'd4, 32'h8000_0000, 32'd31, 0, r, id);

        // Illegal select from r1.
        run_op(0, 0, 1, 4'h0, 4'b0011, 32'd0, 32'd0, 32'h1234_5678, 32'h9, 2, r, id);
        check("illegal_id", id, 1);
        check("illegal_result", r, 32'd0);

        // Long settle, SLTU on the settle-3 instance.
        run_op(1, 1, 0, 4'hE, 4'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, r, id);
        check("sltu_result", r, 32'd1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                w0 = 1'($urandom);
                w1 = 1'($urandom);
                if (!w0 && !w1) w0 = 1'b1;
                run_op(d, w0, w1, 4'($urandom), 4'($urandom), pick(), pick(), pick(), pick(),
                       int'($urandom_range(0, 3)), r, id);
            end
        end

        // Reset during EXEC on the settle-3 instance after an r0 grant (which points prio at r1).
        v0[1] = 1'b1; s0[1] = 4'h0; a0[1] = 32'h0000_1234; b0[1] = 32'h1; v1[1] = 1'b0;
        @(negedge clk);
        check("pre_reset_ready0", rdy0[1], 1);
        @(posedge clk);
        #1;
        v0[1] = 1'b0;
        v1[1] = 1'b1;
        @(negedge clk);
        check("pre_reset_busy", rv[1], 0);
        #1;
        reset = 1'b1;
        v0[1] = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        v0[1] = 1'b0;
        v1[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prio_m[0] = 1'b0;
        prio_m[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_reset_no_rsp_b", rv[1], 0);
            check("post_reset_no_rsp_a", rv[0], 0);
        end
        @(posedge clk);
        #1;
        run_op(1, 1, 1, 4'h4, 4'h2, 32'hA5A5_0000, 32'h0000_5A5A, 32'hFFFF_0000, 32'h00FF_FF00, 1, r, id);
        check("post_reset_first_id", id, 0);
        check("post_reset_result", r, 32'hA5A5_5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
